// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset controller: per-instruction FSM driving datapath enables and mux selects,
// with stored NZCV flags, conditional execution and a memory wait-state handshake.
module multicycle_control_unit #(
  parameter int unsigned          ALUCTRL_W   = 4,
  parameter logic [ALUCTRL_W-1:0] ALU_ADD     = ALUCTRL_W'(4'b0100),
  parameter bit                   MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          instr,
  input  logic [3:0]           alu_flags,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [1:0]           reg_src,
  output logic                 reg_write,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [3:0]           flags,
  output logic                 instr_done
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
    StMemWr, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  state_e     state_q, state_d, cur_state;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       ready;
  logic       cond_holds;
  logic       unused_instr;

  assign cond         = instr[19:16];
  assign op           = instr[15:14];
  assign funct        = instr[13:8];
  assign cmd          = funct[4:1];
  assign rd           = instr[3:0];
  assign unused_instr = ^instr[7:4];
  assign ready        = MEM_WAIT_EN ? mem_ready : 1'b1;

  assign imm_src = op;
  assign reg_src = {op == 2'b01, op == 2'b10};
  assign flags   = flags_q;

  // Condition evaluated against the stored NZCV = {N, Z, C, V}.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_holds = 1'b0;
    unique case (cond)
      4'b0000: cond_holds = z;
      4'b0001: cond_holds = !z;
      4'b0010: cond_holds = c;
      4'b0011: cond_holds = !c;
      4'b0100: cond_holds = n;
      4'b0101: cond_holds = !n;
      4'b0110: cond_holds = v;
      4'b0111: cond_holds = !v;
      4'b1000: cond_holds = c & !z;
      4'b1001: cond_holds = !c | z;
      4'b1010: cond_holds = (n == v);
      4'b1011: cond_holds = (n != v);
      4'b1100: cond_holds = !z & (n == v);
      4'b1101: cond_holds = z | (n != v);
      4'b1110: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // While reset is held the outputs decode as FETCH regardless of the abandoned state.
  assign cur_state = reset ? state_q : StFetch;

  always_comb begin
    state_d     = cur_state;
    flags_d     = flags_q;
    cond_ex_d   = cond_ex_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    reg_write   = 1'b0;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;

    unique case (cur_state)
      StFetch: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        cond_ex_d  = cond_holds;
        unique case (op)
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          default: begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        adr_src = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = cond_ex_q;
        pc_write   = cond_ex_q & (rd == 4'd15);
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = cond_ex_q;
        // A squashed store has nothing to wait for.
        if (ready || !cond_ex_q) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StExecR, StExecI: begin
        alu_src_b   = (cur_state == StExecI) ? 2'b01 : 2'b00;
        alu_control = ALUCTRL_W'(cmd);
        if (funct[0] && cond_ex_q) begin
          flags_d[3:2] = alu_flags[3:2];
          if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) flags_d[1:0] = alu_flags[1:0];
        end
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write  = cond_ex_q & (cmd != 4'b1010);
        pc_write   = cond_ex_q & (cmd != 4'b1010) & (rd == 4'd15);
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex_q;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (!reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instructions cycle by cycle and checks
// enables, selects and stored flags against hand-computed values.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write, instr_done;
  logic [1:0]  result_src, alu_src_b, imm_src, reg_src;
  logic [3:0]  alu_control, flags;
  logic [3:0]  en;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt;

  always #5 clk = ~clk;

  assign en = {pc_write, ir_write, mem_write, reg_write};

  multicycle_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .alu_flags  (alu_flags),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .reg_src    (reg_src),
    .reg_write  (reg_write),
    .alu_control(alu_control),
    .flags      (flags),
    .instr_done (instr_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; instr = 20'hE0921; alu_flags = 4'b0000;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_en", en, 8'h0);
      chk("rst_flags", flags, 8'h0);
      chk("rst_srcb", alu_src_b, 8'h2);
      cyc();
    end

    // ADDS r1,r2,r3
    reset = 1'b1; #1;
    chk("adds_fetch_ir", ir_write, 8'h1);
    chk("adds_fetch_pc", pc_write, 8'h1);
    chk("adds_fetch_alu", alu_control, 8'h4);
    cyc();
    #1; chk("adds_dec_en", en, 8'h0); cyc();
    alu_flags = 4'b0110; #1;
    chk("adds_exec_alu", alu_control, 8'h4);
    chk("adds_exec_srcb", alu_src_b, 8'h0);
    chk("adds_exec_en", en, 8'h0);
    cyc();
    alu_flags = 4'b0000; #1;
    chk("adds_wb_en", en, 8'h1);
    chk("adds_wb_done", instr_done, 8'h1);
    chk("adds_flags", flags, 8'h6);
    cyc();

    // LDR r0,[r1,#4] with three wait cycles
    instr = 20'hE5910; #1;
    chk("ldr_fetch_ir", ir_write, 8'h1); cyc();
    #1; chk("ldr_dec_imm", imm_src, 8'h1); chk("ldr_dec_regsrc", reg_src, 8'h2); cyc();
    #1; chk("ldr_adr_srcb", alu_src_b, 8'h1); chk("ldr_adr_adrsrc", adr_src, 8'h0); cyc();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("ldr_wait_adrsrc", adr_src, 8'h1); chk("ldr_wait_en", en, 8'h0); cyc();
    end
    mem_ready = 1'b1; #1;
    chk("ldr_rd_adrsrc", adr_src, 8'h1); chk("ldr_rd_done", instr_done, 8'h0); cyc();
    #1;
    chk("ldr_wb_res", result_src, 8'h1);
    chk("ldr_wb_en", en, 8'h1);
    chk("ldr_wb_done", instr_done, 8'h1);
    cyc();

    // CMP r1,r2 -> flags 1000
    instr = 20'hE1510; #1; chk("cmp_fetch_ir", ir_write, 8'h1); cyc();
    cyc();
    alu_flags = 4'b1000; #1; chk("cmp_exec_alu", alu_control, 8'hA); cyc();
    alu_flags = 4'b0000; #1;
    chk("cmp_wb_en", en, 8'h0);
    chk("cmp_wb_done", instr_done, 8'h1);
    chk("cmp_flags", flags, 8'h8);
    cyc();

    // ADDNE r0,r1,r2 sees Z=0 from CMP; no S so flags stay
    instr = 20'h10810; cyc(); cyc();
    alu_flags = 4'b1111; cyc();
    alu_flags = 4'b0000; #1;
    chk("addne_wb_regw", reg_write, 8'h1);
    chk("addne_flags", flags, 8'h8);
    cyc();

    // BEQ not taken
    instr = 20'h0A000; done_cnt = 0; #1;
    chk("beq_fetch_pc", pc_write, 8'h1); done_cnt += int'(instr_done); cyc();
    #1; chk("beq_dec_pc", pc_write, 8'h0); done_cnt += int'(instr_done); cyc();
    #1;
    chk("beq_br_pc", pc_write, 8'h0);
    chk("beq_br_srcb", alu_src_b, 8'h1);
    chk("beq_br_res", result_src, 8'h2);
    done_cnt += int'(instr_done);
    chk("beq_done_cnt", 8'(done_cnt), 8'h1);
    cyc();

    // ORRS r0,r1,#imm: only NZ updated
    instr = 20'hE3910; cyc(); cyc();
    alu_flags = 4'b0111; #1;
    chk("orrs_exec_srcb", alu_src_b, 8'h1);
    chk("orrs_exec_alu", alu_control, 8'hC);
    cyc();
    alu_flags = 4'b0000; #1;
    chk("orrs_flags", flags, 8'h4);
    chk("orrs_wb_regw", reg_write, 8'h1);
    cyc();

    // op==11 no-op retires from DECODE
    instr = 20'hEC000; cyc();
    #1; chk("nop_dec_done", instr_done, 8'h1); chk("nop_dec_en", en, 8'h0); cyc();

    // STR r0,[r1], reset asserted mid-MEMWR
    instr = 20'hE5810; #1; chk("str_fetch_ir", ir_write, 8'h1); cyc();
    cyc(); cyc();
    mem_ready = 1'b0; #1;
    chk("str_wr_mw", mem_write, 8'h1); chk("str_wr_adrsrc", adr_src, 8'h1); cyc();
    #1; chk("str_hold_mw", mem_write, 8'h1);
    reset = 1'b0; #1;
    chk("str_rst_mw", mem_write, 8'h0);
    chk("str_rst_en", en, 8'h0);
    chk("str_rst_adrsrc", adr_src, 8'h0);
    cyc();
    reset = 1'b1; mem_ready = 1'b1; #1;
    chk("post_rst_ir", ir_write, 8'h1);
    chk("post_rst_flags", flags, 8'h0);
    cyc();
    #1; chk("post_rst_dec_en", en, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
